lsu: RTL and testbench

Load/store unit for the single-cycle core. It sits between the ALU result and the write-back stage. It turns a load or store into a registered request/grant/response transaction on the data bus, and stalls the core until that transaction finishes. Loads are byte-aligned and sign- or zero-extended before they are presented as the memory write-back data. Misaligned accesses and bus timeouts are flagged, not performed silently.

---
 rtl/lsu.sv | 160 ++++++++++++++++
 tb/tb_lsu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: turns a load or store into one registered req/gnt/rvalid
// data-bus transaction, stalls the core meanwhile and formats load data.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned OP_INFO_WIDTH  = 8,
  parameter int unsigned OP_LOAD        = 0,
  parameter int unsigned OP_STORE       = 1,
  localparam int unsigned XLEN          = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [OP_INFO_WIDTH-1:0] opcode_info_i,
  input  logic [2:0]               funct3_i,
  input  logic [XLEN-1:0]          addr_i,
  input  logic [XLEN-1:0]          store_data_i,
  output logic                     stall_o,
  output logic [XLEN-1:0]          mem_rd_wdata_o,
  output logic                     misalign_o,
  output logic                     bus_err_o,
  output logic                     dbus_req_o,
  output logic                     dbus_we_o,
  output logic [XLEN-1:0]          dbus_addr_o,
  output logic [3:0]               dbus_be_o,
  output logic [XLEN-1:0]          dbus_wdata_o,
  input  logic                     dbus_gnt_i,
  input  logic                     dbus_rvalid_i,
  input  logic [XLEN-1:0]          dbus_rdata_i
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic              is_load, is_store, mem_op, misalign, accept;
  logic              timeout_hit, abort;
  logic [1:0]        size;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rdata_q;
  logic              load_q, uns_q;
  logic [1:0]        size_q, lane_q;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              unused_op_bits;

  assign unused_op_bits = ^opcode_info_i;

  // Access decode: size 00 byte, 01 half, 1x word (undefined encodings act as word)
  assign is_load  = opcode_info_i[OP_LOAD];
  assign is_store = opcode_info_i[OP_STORE];
  assign mem_op   = valid_i & (is_load | is_store);
  assign size     = funct3_i[1] ? 2'b10 : funct3_i[1:0];
  assign misalign = ((size == 2'b01) & addr_i[0]) | ((size == 2'b10) & (|addr_i[1:0]));
  assign accept   = (state_q == ST_IDLE) & mem_op & ~misalign;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data_i;
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << addr_i[1:0];
        wdata_c = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // A response arriving in the timeout cycle still completes normally
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST)) &&
                       ((state_q == ST_REQ) || (state_q == ST_WAIT));
  assign abort       = timeout_hit & ~((state_q == ST_WAIT) & dbus_rvalid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (timeout_hit)     state_d = ST_DONE;
        else if (dbus_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: if (dbus_rvalid_i || timeout_hit) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus-side registers and the captured access attributes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      bus_err_o    <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      load_q       <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
    end else begin
      dbus_req_o <= (state_d == ST_REQ);
      bus_err_o  <= abort;
      if (accept) begin
        dbus_we_o    <= ~is_load;
        dbus_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
        dbus_be_o    <= be_c;
        dbus_wdata_o <= wdata_c;
        load_q       <= is_load;
        uns_q        <= funct3_i[2];
        size_q       <= size;
        lane_q       <= addr_i[1:0];
        cnt_q        <= '0;
      end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (abort)
        rdata_q <= '0;
      else if ((state_q == ST_WAIT) && dbus_rvalid_i && load_q)
        rdata_q <= dbus_rdata_i;
    end
  end

  always_comb begin
    stall_o        = 1'b0;
    misalign_o     = 1'b0;
    mem_rd_wdata_o = '0;
    ld_byte        = 8'(rdata_q >> {lane_q, 3'b000});
    ld_half        = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (state_q)
      ST_IDLE: begin
        stall_o    = mem_op & ~misalign;
        misalign_o = mem_op & misalign;
      end
      ST_REQ, ST_WAIT: stall_o = 1'b1;
      default: ;
    endcase
    if (load_q) begin
      case (size_q)
        2'b00:   mem_rd_wdata_o = {{24{~uns_q & ld_byte[7]}}, ld_byte};
        2'b01:   mem_rd_wdata_o = {{16{~uns_q & ld_half[15]}}, ld_half};
        default: mem_rd_wdata_o = rdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: main instance with default timeout, second with TIMEOUT_CYCLES=4.
module tb_lsu;

  localparam logic [7:0] OPL = 8'b0000_0001;
  localparam logic [7:0] OPS = 8'b0000_0010;

  logic        clk, rst;
  logic        valid, gnt, rvalid;
  logic [7:0]  op_info;
  logic [2:0]  funct3;
  logic [31:0] addr, sdata, rdata;
  logic        stall, misal, berr, req, we;
  logic [31:0] rd_out, d_addr, d_wdata;
  logic [3:0]  d_be;

  logic        valid2, gnt2, rvalid2;
  logic [7:0]  op_info2;
  logic [2:0]  funct3_2;
  logic [31:0] addr2, sdata2, rdata2;
  logic        stall2, misal2, berr2, req2, we2;
  logic [31:0] rd_out2, d_addr2, d_wdata2;
  logic [3:0]  d_be2;

  int errors = 0;
  int checks = 0;

  lsu dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .opcode_info_i(op_info),
    .funct3_i(funct3), .addr_i(addr), .store_data_i(sdata),
    .stall_o(stall), .mem_rd_wdata_o(rd_out), .misalign_o(misal), .bus_err_o(berr),
    .dbus_req_o(req), .dbus_we_o(we), .dbus_addr_o(d_addr), .dbus_be_o(d_be),
    .dbus_wdata_o(d_wdata), .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid), .dbus_rdata_i(rdata)
  );

  lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_i(rst), .valid_i(valid2), .opcode_info_i(op_info2),
    .funct3_i(funct3_2), .addr_i(addr2), .store_data_i(sdata2),
    .stall_o(stall2), .mem_rd_wdata_o(rd_out2), .misalign_o(misal2), .bus_err_o(berr2),
    .dbus_req_o(req2), .dbus_we_o(we2), .dbus_addr_o(d_addr2), .dbus_be_o(d_be2),
    .dbus_wdata_o(d_wdata2), .dbus_gnt_i(gnt2), .dbus_rvalid_i(rvalid2), .dbus_rdata_i(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the main instance; gnt after gw request cycles, rvalid the cycle after grant
  task automatic access(input string tag, input logic [7:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int gw,
                        input logic [31:0] rdv, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic e_we, input logic [31:0] e_wdata, input logic [31:0] e_res,
                        input int e_stall);
    int n;
    int reqn;
    bit granted;
    valid = 1'b1; op_info = op; funct3 = f3; addr = a; sdata = sd;
    n = 0; reqn = 0; granted = 1'b0;
    #1;
    for (int i = 0; i < 64 && stall; i++) begin
      n++;
      gnt = 1'b0; rvalid = 1'b0;
      if (granted) begin
        rvalid = 1'b1; rdata = rdv; granted = 1'b0;
      end else if (req) begin
        chk({tag, ".addr"}, d_addr, e_addr);
        chk({tag, ".be"}, 32'(d_be), 32'(e_be));
        chk({tag, ".we"}, 32'(we), 32'(e_we));
        if (e_we) chk({tag, ".wdata"}, d_wdata, e_wdata);
        if (reqn == gw) begin
          gnt = 1'b1; granted = 1'b1;
        end
        reqn++;
      end
      tick();
    end
    gnt = 1'b0; rvalid = 1'b0;
    chk({tag, ".stall_cycles"}, 32'(n), 32'(e_stall));
    chk({tag, ".result"}, rd_out, e_res);
    chk({tag, ".bus_err"}, 32'(berr), 32'd0);
    valid = 1'b0; op_info = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    valid = 0; gnt = 0; rvalid = 0; op_info = '0; funct3 = '0; addr = '0; sdata = '0; rdata = '0;
    valid2 = 0; gnt2 = 0; rvalid2 = 0; op_info2 = '0; funct3_2 = '0; addr2 = '0; sdata2 = '0; rdata2 = '0;
    repeat (3) tick();

    // Reset state
    chk("rst.req", 32'(req), 32'd0);
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.addr", d_addr, 32'd0);
    chk("rst.be", 32'(d_be), 32'd0);
    chk("rst.wdata", d_wdata, 32'd0);
    chk("rst.bus_err", 32'(berr), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.misalign", 32'(misal), 32'd0);
    chk("rst.rd", rd_out, 32'd0);
    rst = 1'b0;
    tick();

    // Loads: word, sign/zero-extended bytes and halves, undefined funct3 as word
    access("lw",   OPL, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 3);
    access("lb",   OPL, 3'b000, 32'h103, 32'h0, 0, 32'h80FFFF7F, 32'h100, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80, 3);
    access("lbu",  OPL, 3'b100, 32'h103, 32'h0, 0, 32'h80FFFF7F, 32'h100, 4'b1000, 1'b0, 32'h0, 32'h00000080, 3);
    access("lb0",  OPL, 3'b000, 32'h100, 32'h0, 1, 32'h80FFFF7F, 32'h100, 4'b0001, 1'b0, 32'h0, 32'h0000007F, 4);
    access("lh",   OPL, 3'b001, 32'h102, 32'h0, 0, 32'h80FFFF7F, 32'h100, 4'b1100, 1'b0, 32'h0, 32'hFFFF80FF, 3);
    access("lhu",  OPL, 3'b101, 32'h102, 32'h0, 0, 32'h80FFFF7F, 32'h100, 4'b1100, 1'b0, 32'h0, 32'h000080FF, 3);
    access("lw011", OPL, 3'b011, 32'h108, 32'h0, 0, 32'hCAFEF00D, 32'h108, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 3);

    // Stores: half with grant delay, word
    access("sh", OPS, 3'b001, 32'h202, 32'h1234BEEF, 2, 32'h0, 32'h200, 4'b1100, 1'b1, 32'hBEEFBEEF, 32'h0, 5);
    access("sw", OPS, 3'b010, 32'h204, 32'h11223344, 0, 32'h0, 32'h204, 4'b1111, 1'b1, 32'h11223344, 32'h0, 3);

    // SB with gnt held low 5 cycles; inputs changed while busy must not leak through
    valid = 1'b1; op_info = OPS; funct3 = 3'b000; addr = 32'h201; sdata = 32'h123456AB;
    #1 chk("sb.accept_stall", 32'(stall), 32'd1);
    tick();
    addr = 32'h3FF; sdata = 32'h0; funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      chk("sb.hold.req", 32'(req), 32'd1);
      chk("sb.hold.addr", d_addr, 32'h200);
      chk("sb.hold.be", 32'(d_be), 32'h2);
      chk("sb.hold.wdata", d_wdata, 32'hABABABAB);
      chk("sb.hold.we", 32'(we), 32'd1);
      chk("sb.hold.stall", 32'(stall), 32'd1);
      tick();
    end
    chk("sb.gnt.req", 32'(req), 32'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("sb.wait.req", 32'(req), 32'd0);
    chk("sb.wait.stall", 32'(stall), 32'd1);
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("sb.done.stall", 32'(stall), 32'd0);
    chk("sb.done.rd", rd_out, 32'd0);
    valid = 1'b0; op_info = '0;
    tick();

    // Misaligned accesses: flagged, no stall, no request
    valid = 1'b1; op_info = OPL; funct3 = 3'b010; addr = 32'h102;
    #1 chk("lw_mis.misalign", 32'(misal), 32'd1);
    chk("lw_mis.stall", 32'(stall), 32'd0);
    tick();
    chk("lw_mis.req", 32'(req), 32'd0);
    op_info = OPS; funct3 = 3'b001; addr = 32'h101;
    #1 chk("sh_mis.misalign", 32'(misal), 32'd1);
    chk("sh_mis.stall", 32'(stall), 32'd0);
    tick();
    chk("sh_mis.req", 32'(req), 32'd0);
    valid = 1'b0; op_info = '0;
    #1 chk("idle.misalign", 32'(misal), 32'd0);
    tick();

    // Timeout instance: gnt never comes, DONE 5 cycles after acceptance
    valid2 = 1'b1; op_info2 = OPL; funct3_2 = 3'b010; addr2 = 32'h40;
    #1 chk("to.accept_stall", 32'(stall2), 32'd1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("to.req", 32'(req2), 32'd1);
      chk("to.stall", 32'(stall2), 32'd1);
      chk("to.bus_err_early", 32'(berr2), 32'd0);
      tick();
    end
    chk("to.done.req", 32'(req2), 32'd0);
    chk("to.done.stall", 32'(stall2), 32'd0);
    chk("to.done.bus_err", 32'(berr2), 32'd1);
    chk("to.done.rd", rd_out2, 32'd0);
    valid2 = 1'b0; op_info2 = '0;
    tick();
    chk("to.after.bus_err", 32'(berr2), 32'd0);

    // Reset while in REQ: req falls without waiting for a clock edge
    valid = 1'b1; op_info = OPL; funct3 = 3'b010; addr = 32'h300;
    tick();
    chk("rstreq.req_before", 32'(req), 32'd1);
    #2 rst = 1'b1; valid = 1'b0; op_info = '0;
    #1 chk("rstreq.req_async", 32'(req), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset while in WAIT: back to IDLE, late rvalid ignored
    valid = 1'b1; op_info = OPL; funct3 = 3'b010; addr = 32'h300;
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("rstwait.stall_before", 32'(stall), 32'd1);
    rst = 1'b1; valid = 1'b0; op_info = '0;
    #1 chk("rstwait.req", 32'(req), 32'd0);
    chk("rstwait.stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h12345678;
    #1 chk("late_rvalid.stall", 32'(stall), 32'd0);
    tick();
    rvalid = 1'b0;
    chk("late_rvalid.rd", rd_out, 32'd0);
    chk("late_rvalid.req", 32'(req), 32'd0);
    chk("late_rvalid.stall_after", 32'(stall), 32'd0);

    // Back-to-back after reset recovery
    access("lw_b2b1", OPL, 3'b010, 32'h10, 32'h0, 0, 32'h0BADCAFE, 32'h10, 4'b1111, 1'b0, 32'h0, 32'h0BADCAFE, 3);
    access("lw_b2b2", OPL, 3'b000, 32'h12, 32'h0, 0, 32'h00A50000, 32'h10, 4'b0100, 1'b0, 32'h0, 32'hFFFFFFA5, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
